sdram_fifo_ctrl: RTL and testbench

Buffering and arbitration stage between the SDRAM test/user logic and the SDRAM command controller. It accepts a 16-bit write stream into an internal write FIFO and serves a 16-bit read stream from an internal read FIFO. It turns FIFO fill levels into burst write and burst read requests, and generates linear, wrapping SDRAM addresses for each direction. The block is single clock domain, clocked by clk_50m.

---
 rtl/sdram_fifo_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sdram_fifo_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_fifo_ctrl.sv
// Write/read FIFO buffering plus burst arbitration in front of the SDRAM command controller.
// Fill levels become burst requests; each direction walks its own wrapping address window.
module sdram_fifo_ctrl #(
  parameter int unsigned FIFO_AW  = 10,
  parameter int unsigned BURST    = 256,
  parameter logic [23:0] ADDR_MIN = 24'd0,
  parameter logic [23:0] ADDR_MAX = 24'd2048
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_wr_addr,
  output logic [15:0] sdram_din,
  output logic        sdram_rd_req,
  input  logic        sdram_rd_ack,
  output logic [23:0] sdram_rd_addr,
  input  logic [15:0] sdram_dout,
  output logic [9:0]  sdram_burst,
  output logic        wr_overflow,
  output logic        rd_underflow
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam int unsigned BeatW = $clog2(BURST + 1);
  localparam logic [CntW-1:0]  DepthC = CntW'(Depth);
  localparam logic [CntW-1:0]  BurstC = CntW'(BURST);
  localparam logic [BeatW-1:0] BurstB = BeatW'(BURST);
  localparam logic [23:0]      BurstA = 24'(BURST);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e             state_q, state_d;
  logic               wr_req_q, wr_req_d;
  logic               rd_req_q, rd_req_d;
  logic               last_wr_q, last_wr_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [23:0]        wr_addr_q, wr_addr_d;
  logic [23:0]        rd_addr_q, rd_addr_d;

  logic [15:0]        wmem [Depth];
  logic [15:0]        rmem [Depth];
  logic [FIFO_AW-1:0] wwp_q, wrp_q, rwp_q, rrp_q;
  logic [CntW-1:0]    wcnt_q, rcnt_q;
  logic [15:0]        rd_data_q;
  logic               ovf_q, unf_q;

  logic wr_full, wr_empty, rd_full, rd_empty;
  logic wpush, wpop, rpush, rpop;
  logic wr_ready, rd_ready;

  assign wr_full  = (wcnt_q == DepthC);
  assign wr_empty = (wcnt_q == '0);
  assign rd_full  = (rcnt_q == DepthC);
  assign rd_empty = (rcnt_q == '0);

  // Acks only move data while the FSM owns the matching direction.
  assign wpush = wr_en && !wr_full;
  assign wpop  = sdram_wr_ack && (state_q == StWrite) && !wr_empty;
  assign rpush = sdram_rd_ack && (state_q == StRead) && !rd_full;
  assign rpop  = rd_en && !rd_empty;

  function automatic logic [23:0] next_addr(input logic [23:0] a);
    logic [23:0] n;
    n = a + BurstA;
    return (n >= ADDR_MAX) ? ADDR_MIN : n;
  endfunction

  always_ff @(posedge clk_50m) begin
    if (wpush) wmem[wwp_q] <= wr_data;
    if (rpush) rmem[rwp_q] <= sdram_dout;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wwp_q     <= '0;
      wrp_q     <= '0;
      wcnt_q    <= '0;
      rwp_q     <= '0;
      rrp_q     <= '0;
      rcnt_q    <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (wpush) wwp_q <= wwp_q + 1'b1;
      if (wpop)  wrp_q <= wrp_q + 1'b1;
      if (wpush && !wpop)      wcnt_q <= wcnt_q + 1'b1;
      else if (wpop && !wpush) wcnt_q <= wcnt_q - 1'b1;
      if (rpush) rwp_q <= rwp_q + 1'b1;
      if (rpop)  rrp_q <= rrp_q + 1'b1;
      if (rpush && !rpop)      rcnt_q <= rcnt_q + 1'b1;
      else if (rpop && !rpush) rcnt_q <= rcnt_q - 1'b1;
      if (rpop) rd_data_q <= rmem[rrp_q];
      if (wr_en && wr_full)  ovf_q <= 1'b1;
      if (rd_en && rd_empty) unf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      last_wr_q <= 1'b0;
      beat_q    <= '0;
      wr_addr_q <= ADDR_MIN;
      rd_addr_q <= ADDR_MIN;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      last_wr_q <= last_wr_d;
      beat_q    <= beat_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    last_wr_d = last_wr_q;
    beat_d    = beat_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_ready  = (wcnt_q >= BurstC);
    rd_ready  = ((DepthC - rcnt_q) >= BurstC);
    unique case (state_q)
      StIdle: begin
        if (sdram_init_done) begin
          // On a tie, the side that lost last time wins.
          if (wr_ready && (!rd_ready || !last_wr_q)) begin
            state_d   = StWrite;
            wr_req_d  = 1'b1;
            beat_d    = '0;
            last_wr_d = 1'b1;
          end else if (rd_ready) begin
            state_d   = StRead;
            rd_req_d  = 1'b1;
            beat_d    = '0;
            last_wr_d = 1'b0;
          end
        end
      end
      StWrite: begin
        if (sdram_wr_ack) begin
          wr_req_d = 1'b0;
          beat_d   = beat_q + 1'b1;
          if (beat_d == BurstB) begin
            wr_addr_d = next_addr(wr_addr_q);
            state_d   = StIdle;
          end
        end
      end
      StRead: begin
        if (sdram_rd_ack) begin
          rd_req_d = 1'b0;
          beat_d   = beat_q + 1'b1;
          if (beat_d == BurstB) begin
            rd_addr_d = next_addr(rd_addr_q);
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_data       = rd_data_q;
  assign sdram_wr_req  = wr_req_q;
  assign sdram_rd_req  = rd_req_q;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_rd_addr = rd_addr_q;
  // Show-ahead head word; forced to zero while the FIFO is empty.
  assign sdram_din     = wr_empty ? 16'd0 : wmem[wrp_q];
  assign sdram_burst   = 10'(BURST);
  assign wr_overflow   = ovf_q;
  assign rd_underflow  = unf_q;

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Bench for sdram_fifo_ctrl: SDRAM controller model, queue-based reference FIFOs and a
// negedge monitor that scores every data beat, read word, burst address and grant.
module tb_sdram_fifo_ctrl;

  localparam int Burst  = 256;
  localparam int Depth  = 1024;
  localparam int Region = 2048;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        sdram_wr_req;
  logic        wr_ack = 1'b0;
  logic [23:0] sdram_wr_addr;
  logic [15:0] din;
  logic        sdram_rd_req;
  logic        rd_ack = 1'b0;
  logic [23:0] sdram_rd_addr;
  logic [15:0] dout = '0;
  logic [9:0]  sdram_burst;
  logic        wr_overflow;
  logic        rd_underflow;

  sdram_fifo_ctrl dut (
    .clk_50m        (clk_50m),
    .rst_n          (rst_n),
    .sdram_init_done(init_done),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .sdram_wr_req   (sdram_wr_req),
    .sdram_wr_ack   (wr_ack),
    .sdram_wr_addr  (sdram_wr_addr),
    .sdram_din      (din),
    .sdram_rd_req   (sdram_rd_req),
    .sdram_rd_ack   (rd_ack),
    .sdram_rd_addr  (sdram_rd_addr),
    .sdram_dout     (dout),
    .sdram_burst    (sdram_burst),
    .wr_overflow    (wr_overflow),
    .rd_underflow   (rd_underflow)
  );

  always #10 clk_50m = ~clk_50m;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] wq[$];
  logic [15:0] rq[$];
  logic [15:0] exp_rd = '0;
  bit          rd_pend = 0;
  bit          exp_ovf = 0;
  bit          exp_unf = 0;
  bit          wfull, rempty;
  int          nwr = 0;
  int          nrd = 0;
  int          ctrl_beats = 0;
  bit          busy = 0;
  bit          busy_wr = 0;
  bit          gaps = 0;
  bit          grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: condition not reached", name);
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  // Reference model: FIFOs are plain queues, updated with what the coming edge will do.
  always @(negedge clk_50m) begin
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      exp_rd  = '0;
      rd_pend = 0;
      exp_ovf = 0;
      exp_unf = 0;
    end else begin
      if (rd_pend) chk("rd_data", 32'(rd_data), 32'(exp_rd));
      rd_pend = rd_en;
      wfull   = (wq.size() == Depth);
      if (wr_ack) begin
        if (wq.size() == 0) fail_now("sdram_din_model_empty");
        else chk("sdram_din", 32'(din), 32'(wq.pop_front()));
      end
      if (wr_en) begin
        if (!wfull) wq.push_back(wr_data);
        else exp_ovf = 1;
      end
      rempty = (rq.size() == 0);
      if (rd_en) begin
        if (!rempty) exp_rd = rq.pop_front();
        else exp_unf = 1;
      end
      if (rd_ack) rq.push_back(dout);
    end
  end

  task automatic serve(input bit is_wr, input logic [23:0] a);
    ctrl_beats = 0;
    busy       = 1;
    busy_wr    = is_wr;
    while (ctrl_beats < Burst) begin
      tick();
      if (!rst_n) break;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        wr_ack = 1'b0;
        rd_ack = 1'b0;
      end else begin
        if (is_wr) wr_ack = 1'b1;
        else begin
          rd_ack = 1'b1;
          dout   = 16'(a + 24'(ctrl_beats) + 24'd1);
        end
        ctrl_beats++;
      end
    end
    if (rst_n) begin
      @(negedge clk_50m);
      chk(is_wr ? "wr_addr_stable" : "rd_addr_stable",
          32'(is_wr ? sdram_wr_addr : sdram_rd_addr), 32'(a));
      tick();
    end
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    if (rst_n && ctrl_beats == Burst) begin
      if (is_wr) nwr++;
      else nrd++;
    end
    busy = 0;
  endtask

  // SDRAM controller model: burst n of a direction must start at (n*BURST) mod region.
  initial begin
    forever begin
      @(negedge clk_50m);
      if (!rst_n) begin
        nwr = 0;
        nrd = 0;
      end else if (sdram_wr_req) begin
        grants.push_back(1'b1);
        chk("wr_burst_addr", 32'(sdram_wr_addr), (nwr * Burst) % Region);
        serve(1'b1, sdram_wr_addr);
      end else if (sdram_rd_req) begin
        grants.push_back(1'b0);
        chk("rd_burst_addr", 32'(sdram_rd_addr), (nrd * Burst) % Region);
        serve(1'b0, sdram_rd_addr);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_wr_req"}, 32'(sdram_wr_req), 0);
    chk({tag, "_rd_req"}, 32'(sdram_rd_req), 0);
    chk({tag, "_wr_addr"}, 32'(sdram_wr_addr), 0);
    chk({tag, "_rd_addr"}, 32'(sdram_rd_addr), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_din"}, 32'(din), 0);
    chk({tag, "_ovf"}, 32'(wr_overflow), 0);
    chk({tag, "_unf"}, 32'(rd_underflow), 0);
    chk({tag, "_burst"}, 32'(sdram_burst), Burst);
  endtask

  initial begin
    // Reset values
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk_50m);
    check_reset("reset");

    // Overflow: 1025 words with no acks; the last one is dropped
    for (int i = 1; i <= 1025; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    @(negedge clk_50m);
    chk("wr_overflow_set", 32'(wr_overflow), 1);
    chk("rd_underflow_clear", 32'(rd_underflow), 0);

    // Tie arbitration: full write FIFO and empty read FIFO when init completes
    init_done = 1'b1;
    begin
      int k = 0;
      while (!(grants.size() >= 8 && !busy) && k < 6000) begin tick(); k++; end
      if (!(grants.size() >= 8)) fail_now("tie_grants");
    end
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk($sformatf("grant_%0d", i), 32'(grants[i]), ((i % 2) == 0) ? 1 : 0);
    repeat (3) tick();

    // Read latency: first word one cycle after rd_en, then a 256-word stream
    rd_en = 1'b1;
    tick();
    @(negedge clk_50m);
    chk("rd_first_word", 32'(rd_data), 1);
    for (int i = 1; i < Burst; i++) tick();
    rd_en = 1'b0;
    tick();
    @(negedge clk_50m);
    chk("rd_underflow_after_reads", 32'(rd_underflow), 0);

    // Randomized traffic with ack gaps; write addresses run through the wrap
    gaps = 1;
    for (int i = 0; i < 6000; i++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_data = 16'($urandom);
      rd_en   = ($urandom_range(0, 1) == 1) && (rq.size() > 0);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wrap_reached", 32'(nwr >= 9), 1);

    // Underflow: halt bursts, drain the read FIFO, then read once more
    gaps      = 0;
    init_done = 1'b0;
    repeat (4) tick();
    begin
      int k = 0;
      while ((busy || sdram_wr_req || sdram_rd_req) && k < 3000) begin tick(); k++; end
      if (busy) fail_now("halt_idle");
    end
    repeat (3) tick();
    begin
      int n;
      n = rq.size();
      rd_en = 1'b1;
      for (int i = 0; i <= n; i++) tick();
      rd_en = 1'b0;
    end
    tick();
    @(negedge clk_50m);
    chk("rd_underflow_set", 32'(rd_underflow), 1);
    chk("wr_overflow_sticky", 32'(wr_overflow), 1);

    // Reset in the middle of a write burst
    tick();
    for (int i = 0; i < Burst; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'($urandom);
      tick();
    end
    wr_en     = 1'b0;
    init_done = 1'b1;
    begin
      int k = 0;
      while (!(busy && busy_wr && ctrl_beats >= 100) && k < 3000) begin tick(); k++; end
      if (!(busy && busy_wr)) fail_now("midburst_write");
    end
    #3 rst_n  = 1'b0;
    init_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk_50m);
    check_reset("midreset");

    // Write threshold after reset: 255 words hold off, the 256th requests at address 0
    tick();
    init_done = 1'b1;
    begin
      int k = 0;
      while (!(nrd == 4 && !busy) && k < 3000) begin tick(); k++; end
      if (nrd != 4) fail_now("prefetch_done");
    end
    repeat (3) tick();
    for (int i = 1; i <= 255; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50m);
      chk("wr_req_below_burst", 32'(sdram_wr_req), 0);
      tick();
    end
    wr_en   = 1'b1;
    wr_data = 16'd256;
    tick();
    wr_en = 1'b0;
    @(negedge clk_50m);
    chk("wr_req_decision_cycle", 32'(sdram_wr_req), 0);
    @(negedge clk_50m);
    chk("wr_req_rise", 32'(sdram_wr_req), 1);
    chk("wr_req_addr", 32'(sdram_wr_addr), 0);
    begin
      int k = 0;
      while (!(nwr == 1 && !busy) && k < 2000) begin tick(); k++; end
      if (nwr != 1) fail_now("threshold_burst_done");
    end
    tick();
    @(negedge clk_50m);
    chk("final_ovf", 32'(wr_overflow), 32'(exp_ovf));
    chk("final_unf", 32'(rd_underflow), 32'(exp_unf));
    chk("final_wr_queue_empty", wq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
